// File: rtl/audio_pkg.sv
// Shared constants and types for the audio DAC serializer.
package audio_pkg;

    localparam int SAMPLE_W_DEF    = 24;
    localparam int BITS_PER_CH_DEF = 32;

    typedef logic [SAMPLE_W_DEF-1:0] sample_t;

endpackage

// File: rtl/audio_bclk_div.sv
// BCLK generator: divides clk by 2*BCLK_HALF; rise/fall strobes are high in the
// cycle whose closing edge toggles bclk, so consumers update in step with it.
module audio_bclk_div #(
    parameter int BCLK_HALF = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_bclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [DW-1:0] r_div;
    logic          r_bclk;
    logic          w_wrap;

    assign w_wrap = (r_div == DW'(BCLK_HALF - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else begin
            r_div <= w_wrap ? '0 : r_div + 1'b1;
            if (w_wrap)
                r_bclk <= ~r_bclk;
        end
    end

    assign o_bclk = r_bclk;
    assign o_rise = w_wrap & ~r_bclk;
    assign o_fall = w_wrap & r_bclk;

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S mono-to-stereo DAC serializer with one-deep holding register.
// Optional AUDIO_DAC_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W    = SAMPLE_W_DEF,
    parameter int BCLK_HALF   = 4,
    parameter int BITS_PER_CH = BITS_PER_CH_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                dacdat,
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    output logic [15:0]         underrun_count,
`endif
    output logic                underrun
);

    localparam int NSLOT = 2 * BITS_PER_CH;
    localparam int BW    = $clog2(NSLOT);

    logic [BW-1:0]       r_b;
    logic                r_lrclk;
    logic                r_dacdat;
    logic                r_underrun;
    logic                r_ready;
    logic                r_hold_full;
    logic [SAMPLE_W-1:0] r_hold;
    logic [SAMPLE_W-1:0] r_frame;

    logic          w_bclk, w_rise, w_fall;
    logic [BW-1:0] w_b_nxt, w_k;
    logic          w_lr_nxt, w_bit, w_load, w_accept, w_full_nxt;

    audio_bclk_div #(.BCLK_HALF(BCLK_HALF)) u_div (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .o_bclk  (w_bclk),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_b_nxt  = (r_b == BW'(NSLOT - 1)) ? '0 : r_b + 1'b1;
    assign w_lr_nxt = (w_b_nxt >= BW'(BITS_PER_CH));
    assign w_k      = w_lr_nxt ? w_b_nxt - BW'(BITS_PER_CH) : w_b_nxt;

    // Slot k carries frame bit SAMPLE_W-k; slot 0 is the I2S delay slot, tail is zero pad
    always_comb begin
        w_bit = 1'b0;
        for (int i = 0; i < SAMPLE_W; i++)
            if (w_k == BW'(SAMPLE_W - i))
                w_bit = r_frame[i];
    end

    assign w_load     = w_fall && (w_b_nxt == '0);
    assign w_accept   = sample_valid && r_ready;
    // A same-cycle accept always lands in hold; the frame never bypasses it
    assign w_full_nxt = w_accept ? 1'b1 : (w_load ? 1'b0 : r_hold_full);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_b         <= BW'(NSLOT - 1);
            r_lrclk     <= 1'b1;
            r_dacdat    <= 1'b0;
            r_underrun  <= 1'b0;
            r_ready     <= 1'b1;
            r_hold_full <= 1'b0;
            r_hold      <= '0;
            r_frame     <= '0;
        end else begin
            if (w_accept)
                r_hold <= sample;
            r_hold_full <= w_full_nxt;
            r_ready     <= !w_full_nxt;
            r_underrun  <= w_load && !r_hold_full;
            if (w_load && r_hold_full)
                r_frame <= r_hold;
            if (w_fall) begin
                r_b      <= w_b_nxt;
                r_lrclk  <= w_lr_nxt;
                r_dacdat <= w_bit;
            end
        end
    end

`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    logic [15:0] r_ucnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ucnt <= '0;
        else if (w_load && !r_hold_full && r_ucnt != 16'hFFFF)
            r_ucnt <= r_ucnt + 16'd1;
    end

    assign underrun_count = r_ucnt;
`endif

    a_strobe_excl: assert property (@(posedge clk) disable iff (!reset_n) !(w_rise && w_fall));

    assign sample_ready = r_ready;
    assign bclk         = w_bclk;
    assign lrclk        = r_lrclk;
    assign dacdat       = r_dacdat;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer at BCLK_HALF=2, BITS_PER_CH=32, SAMPLE_W=24.
module tb_audio_dac_serializer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, bclk, lrclk, dacdat, underrun;
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    int checks = 0;
    int errors = 0;

    // Expected 64-slot frames, bit s = slot s
    localparam logic [63:0] PAT_FF0000 = 64'h000001FE_000001FE;
    localparam logic [63:0] PAT_00FFFF = 64'h01FFFE00_01FFFE00;
    localparam logic [63:0] PAT_LR     = 64'hFFFFFFFF_00000000;

    audio_dac_serializer #(.SAMPLE_W(24), .BCLK_HALF(2), .BITS_PER_CH(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample         (sample),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .bclk           (bclk),
        .lrclk          (lrclk),
        .dacdat         (dacdat),
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
        .underrun_count (underrun_count),
`endif
        .underrun       (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        step();
        step();
    endtask

    // Records one frame starting at a frame-load cycle; drops sample_valid on handshake
    task automatic capture(output logic [63:0] bits, output logic [63:0] lr,
                           output int urun, output int badchg);
        logic pb, pd, hs;
        urun = 0;
        badchg = 0;
        bits = '0;
        lr = '0;
        for (int i = 0; i < 256; i++) begin
            if (i % 4 == 0) begin
                bits[i/4] = dacdat;
                lr[i/4]   = lrclk;
            end
            if (underrun) urun++;
            pb = bclk;
            pd = dacdat;
            hs = sample_valid && sample_ready;
            step();
            if (hs) sample_valid = 1'b0;
            if (dacdat !== pd && !(pb && !bclk)) badchg++;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_bclk;
        exp_bclk = 4'b0110;
        do_reset();
        checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL rst_bclk got %b want 0", bclk); end
        checks++; if (lrclk !== 1'b1) begin errors++; $display("FAIL rst_lrclk got %b want 1", lrclk); end
        checks++; if (dacdat !== 1'b0) begin errors++; $display("FAIL rst_dacdat got %b want 0", dacdat); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b want 0", underrun); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", sample_ready); end
        reset_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (bclk !== exp_bclk[c-1]) begin
                errors++; $display("FAIL start_bclk cycle %0d got %b want %b", c, bclk, exp_bclk[c-1]);
            end
            if (c == 3) begin
                checks++; if (underrun !== 1'b0 || lrclk !== 1'b1) begin
                    errors++; $display("FAIL pre_load cycle 3 underrun=%b lrclk=%b want 0/1", underrun, lrclk);
                end
            end
        end
        checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL first_fall_lrclk got %b want 0", lrclk); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL first_fall_underrun got %b want 1", underrun); end
    endtask

    task automatic test_idle();
        logic [63:0] bits, lr;
        int urun, badchg;
        capture(bits, lr, urun, badchg);
        checks++; if (bits !== 64'h0) begin errors++; $display("FAIL idle_data got %h want 0", bits); end
        checks++; if (lr !== PAT_LR) begin errors++; $display("FAIL idle_lrclk got %h want %h", lr, PAT_LR); end
        checks++; if (urun !== 1) begin errors++; $display("FAIL idle_underrun_count got %0d want 1", urun); end
        checks++; if (badchg !== 0) begin errors++; $display("FAIL idle_dacdat_edges got %0d want 0", badchg); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL idle_next_underrun got %b want 1", underrun); end
    endtask

    task automatic test_single();
        logic [63:0] bits, lr;
        int urun, badchg;
        do_reset();
        reset_n = 1'b1;
        sample = 24'hFF0000;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL single_ready_after_push got %b want 0", sample_ready); end
        repeat (3) step();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL single_load_underrun got %b want 0", underrun); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after_load got %b want 1", sample_ready); end
        capture(bits, lr, urun, badchg);
        checks++; if (bits !== PAT_FF0000) begin errors++; $display("FAIL single_data got %h want %h", bits, PAT_FF0000); end
        checks++; if (lr !== PAT_LR) begin errors++; $display("FAIL single_lrclk got %h want %h", lr, PAT_LR); end
        checks++; if (urun !== 0 || badchg !== 0) begin errors++; $display("FAIL single_flags urun=%0d badchg=%0d want 0/0", urun, badchg); end
        capture(bits, lr, urun, badchg);
        checks++; if (bits !== PAT_FF0000) begin errors++; $display("FAIL repeat_data got %h want %h", bits, PAT_FF0000); end
        checks++; if (urun !== 1) begin errors++; $display("FAIL repeat_underrun got %0d want 1", urun); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] bits, lr;
        int urun, badchg;
        do_reset();
        sample = 24'h00FFFF;
        sample_valid = 1'b1;
        reset_n = 1'b1;
        step();
        sample = 24'hFF0000;
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_c1 got %b want 0", sample_ready); end
        step();
        step();
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_c3 got %b want 0", sample_ready); end
        step();
        checks++; if (sample_ready !== 1'b1 || underrun !== 1'b0) begin
            errors++; $display("FAIL b2b_load ready=%b underrun=%b want 1/0", sample_ready, underrun);
        end
        capture(bits, lr, urun, badchg);
        checks++; if (bits !== PAT_00FFFF) begin errors++; $display("FAIL b2b_first got %h want %h", bits, PAT_00FFFF); end
        checks++; if (urun !== 0 || sample_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_flags urun=%0d valid=%b want 0/0", urun, sample_valid); end
        checks++; if (underrun !== 1'b0 || sample_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_second_load underrun=%b ready=%b want 0/1", underrun, sample_ready);
        end
        capture(bits, lr, urun, badchg);
        checks++; if (bits !== PAT_FF0000) begin errors++; $display("FAIL b2b_second got %h want %h", bits, PAT_FF0000); end
        checks++; if (urun !== 0) begin errors++; $display("FAIL b2b_second_underrun got %0d want 0", urun); end
        capture(bits, lr, urun, badchg);
        checks++; if (bits !== PAT_FF0000 || urun !== 1) begin
            errors++; $display("FAIL b2b_repeat data=%h urun=%0d want %h/1", bits, urun, PAT_FF0000);
        end
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
        checks++; if (underrun_count !== 16'd2) begin errors++; $display("FAIL underrun_count got %0d want 2", underrun_count); end
`endif
    endtask

    task automatic test_load_accept();
        logic [63:0] bits, lr;
        int urun, badchg;
        do_reset();
        reset_n = 1'b1;
        repeat (3) step();
        sample = 24'h00FFFF;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        checks++; if (underrun !== 1'b1 || sample_ready !== 1'b0) begin
            errors++; $display("FAIL la_load underrun=%b ready=%b want 1/0", underrun, sample_ready);
        end
        capture(bits, lr, urun, badchg);
        checks++; if (bits !== 64'h0) begin errors++; $display("FAIL la_first got %h want 0", bits); end
        capture(bits, lr, urun, badchg);
        checks++; if (bits !== PAT_00FFFF || urun !== 0) begin
            errors++; $display("FAIL la_second data=%h urun=%0d want %h/0", bits, urun, PAT_00FFFF);
        end
    endtask

    task automatic test_mid_reset();
        logic [63:0] bits, lr;
        int urun, badchg;
        sample = 24'hFF0000;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (147) step();
        checks++; if (lrclk !== 1'b1) begin errors++; $display("FAIL mr_right_channel lrclk got %b want 1", lrclk); end
        reset_n = 1'b0;
        #1;
        checks++; if (bclk !== 1'b0 || lrclk !== 1'b1 || dacdat !== 1'b0 || underrun !== 1'b0 || sample_ready !== 1'b1) begin
            errors++; $display("FAIL mr_async bclk=%b lrclk=%b dacdat=%b underrun=%b ready=%b want 0/1/0/0/1",
                               bclk, lrclk, dacdat, underrun, sample_ready);
        end
        step();
        reset_n = 1'b1;
        repeat (3) step();
        checks++; if (bclk !== 1'b1 || lrclk !== 1'b1) begin errors++; $display("FAIL mr_restart_c3 bclk=%b lrclk=%b want 1/1", bclk, lrclk); end
        step();
        checks++; if (underrun !== 1'b1 || lrclk !== 1'b0) begin
            errors++; $display("FAIL mr_restart_load underrun=%b lrclk=%b want 1/0", underrun, lrclk);
        end
        capture(bits, lr, urun, badchg);
        checks++; if (bits !== 64'h0) begin errors++; $display("FAIL mr_discard got %h want 0", bits); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_load_accept();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
